// File: rtl/bias_accum_relu_unit.sv
// bias_accum_relu_unit
// Accumulates N_PASS partial-sum vectors per output vector, adding the lane bias
// on the first pass only. Each lane saturates to 18 bits, optionally applies ReLU,
// and the finished vector is held on a valid/ready output until it is taken.
module bias_accum_relu_unit #(
  parameter int N_adder_tree = 16,
  parameter int N_PASS       = 4,
  parameter int ACC_W        = 22,
  parameter int RELU         = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_adder_tree*18-1:0]   in_data,
  input  logic [N_adder_tree*18-1:0]   bias,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_adder_tree*18-1:0]   out_data,
  output logic [$clog2(N_PASS):0]      pass_cnt
);

  localparam int CNT_W = $clog2(N_PASS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PASS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(131071);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-131072);

  typedef enum logic {
    ACCUM = 1'b0,
    OUT   = 1'b1
  } state_t;

  state_t             state_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic [CNT_W-1:0]   pass_cnt_reg;

  logic accept;
  logic first_pass;
  logic last_pass;

  // in_ready_reg is only high in ACCUM, so it doubles as the state qualifier here
  assign accept     = in_valid && in_ready_reg;
  assign first_pass = (pass_cnt_reg == '0);
  assign last_pass  = (pass_cnt_reg == LAST_CNT);

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign pass_cnt  = pass_cnt_reg;

  // Control FSM: pass counting and registered handshake flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ACCUM;
      pass_cnt_reg  <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (accept) begin
            if (last_pass) begin
              state_reg     <= OUT;
              pass_cnt_reg  <= '0;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
            end else begin
              pass_cnt_reg <= pass_cnt_reg + 1'b1;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state_reg     <= ACCUM;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= ACCUM;
          pass_cnt_reg  <= '0;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_adder_tree; gi++) begin : g_lane
      logic signed [ACC_W-1:0] acc_reg;
      logic signed [ACC_W-1:0] in_ext;
      logic signed [ACC_W-1:0] bias_ext;
      logic signed [ACC_W-1:0] base;
      logic signed [ACC_W-1:0] sum;
      logic [17:0]             sat;
      logic [17:0]             res;
      logic [17:0]             out_reg;

      assign in_ext   = {{(ACC_W-18){in_data[gi*18+17]}}, in_data[gi*18 +: 18]};
      assign bias_ext = {{(ACC_W-18){bias[gi*18+17]}}, bias[gi*18 +: 18]};
      // the first pass restarts the lane from its bias instead of the old total
      assign base     = first_pass ? bias_ext : acc_reg;
      assign sum      = base + in_ext;

      // Clamp the full-width total to the signed 18-bit range, then optional ReLU
      always_comb begin
        sat = sum[17:0];
        if (sum > SAT_MAX) begin
          sat = 18'h1FFFF;
        end else if (sum < SAT_MIN) begin
          sat = 18'h20000;
        end
        res = sat;
        if ((RELU != 0) && sat[17]) begin
          res = '0;
        end
      end

      // Lane accumulator and output register, both updated only on an accepted pass
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          acc_reg <= '0;
          out_reg <= '0;
        end else if (accept) begin
          acc_reg <= sum;
          if (last_pass) begin
            out_reg <= res;
          end
        end
      end

      assign out_data[gi*18 +: 18] = out_reg;
    end
  endgenerate

endmodule

// File: tb/tb_bias_accum_relu_unit.sv
// Testbench for bias_accum_relu_unit: one ReLU instance and one linear instance
// share the same stimulus. Table vectors, hand-written corner sequences and
// randomized vectors checked against an integer-arithmetic reference model.
module tb_bias_accum_relu_unit;

  localparam int N     = 16;
  localparam int NP    = 4;
  localparam int ACC_W = 22;
  localparam int BUS   = N * 18;
  localparam int CW    = $clog2(NP) + 1;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic [BUS-1:0] in_data;
  logic [BUS-1:0] bias;
  logic           out_ready;

  logic           in_ready_r, out_valid_r;
  logic [BUS-1:0] out_data_r;
  logic [CW-1:0]  pass_cnt_r;
  logic           in_ready_l, out_valid_l;
  logic [BUS-1:0] out_data_l;
  logic [CW-1:0]  pass_cnt_l;

  bias_accum_relu_unit #(.N_adder_tree(N), .N_PASS(NP), .ACC_W(ACC_W), .RELU(1)) u_relu (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r),
    .in_data(in_data), .bias(bias), .out_valid(out_valid_r), .out_ready(out_ready),
    .out_data(out_data_r), .pass_cnt(pass_cnt_r)
  );

  bias_accum_relu_unit #(.N_adder_tree(N), .N_PASS(NP), .ACC_W(ACC_W), .RELU(0)) u_lin (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_data(in_data), .bias(bias), .out_valid(out_valid_l), .out_ready(out_ready),
    .out_data(out_data_l), .pass_cnt(pass_cnt_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [17:0] i0;
    logic signed [17:0] i1;
    logic signed [17:0] i2;
    logic signed [17:0] i3;
    logic signed [17:0] b;
    logic signed [17:0] e_relu;
    logic signed [17:0] e_lin;
  } vec_t;

  vec_t           tbl [6];
  logic [BUS-1:0] pass_data [NP];
  int             n_vec = 0;
  int             n_bad = 0;
  int             vec_id = 0;

  task automatic check(input string name, input logic [BUS-1:0] act, input logic [BUS-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (vec %0d): got %h required %h", name, vec_id, act, exp);
    end
  endtask

  function automatic logic [BUS-1:0] bcast(input logic [17:0] v);
    logic [BUS-1:0] r;
    for (int i = 0; i < N; i++) r[i*18 +: 18] = v;
    return r;
  endfunction

  function automatic logic [BUS-1:0] rand_bus();
    logic [BUS-1:0] r;
    for (int i = 0; i < N; i++) r[i*18 +: 18] = 18'($urandom);
    return r;
  endfunction

  function automatic int lane_val(input logic [BUS-1:0] v, input int i);
    logic signed [17:0] x;
    x = v[i*18 +: 18];
    return int'(x);
  endfunction

  // Reference: integer sum of bias plus all passes, clamp, optional ReLU
  function automatic logic [BUS-1:0] model(input logic [BUS-1:0] b, input bit relu);
    logic [BUS-1:0] r;
    int s;
    for (int i = 0; i < N; i++) begin
      s = lane_val(b, i);
      for (int p = 0; p < NP; p++) s += lane_val(pass_data[p], i);
      if (s > 131071) s = 131071;
      else if (s < -131072) s = -131072;
      if (relu && s < 0) s = 0;
      r[i*18 +: 18] = 18'(s);
    end
    return r;
  endfunction

  task automatic check_ctrl(input string name, input bit exp_ready, input bit exp_valid);
    check({name, "_in_ready_r"}, BUS'(in_ready_r), BUS'(exp_ready));
    check({name, "_in_ready_l"}, BUS'(in_ready_l), BUS'(exp_ready));
    check({name, "_out_valid_r"}, BUS'(out_valid_r), BUS'(exp_valid));
    check({name, "_out_valid_l"}, BUS'(out_valid_l), BUS'(exp_valid));
  endtask

  // Applies pass_data with bias b on pass 0 (garbage bias afterwards), random
  // bubbles up to max_gap, then holds the result for 'hold' cycles before taking it.
  task automatic run_vec(input logic [BUS-1:0] b, input int max_gap, input int hold,
                         input logic [BUS-1:0] exp_r, input logic [BUS-1:0] exp_l);
    for (int p = 0; p < NP; p++) begin
      repeat ($urandom_range(0, max_gap)) begin
        in_valid = 1'b0;
        in_data  = rand_bus();
        bias     = rand_bus();
        @(posedge clk); #1;
        check("gap_pass_cnt", BUS'(pass_cnt_r), BUS'(p));
      end
      check_ctrl("accum", 1'b1, 1'b0);
      in_valid = 1'b1;
      in_data  = pass_data[p];
      bias     = (p == 0) ? b : rand_bus();
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("pass_cnt_r", BUS'(pass_cnt_r), BUS'((p == NP-1) ? 0 : p + 1));
      check("pass_cnt_l", BUS'(pass_cnt_l), BUS'((p == NP-1) ? 0 : p + 1));
      check("latency_valid", BUS'(out_valid_r), BUS'(p == NP-1));
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      in_data  = rand_bus();
      bias     = rand_bus();
      @(posedge clk); #1;
      check_ctrl("hold", 1'b0, 1'b1);
      check("hold_data_r", out_data_r, exp_r);
      check("hold_data_l", out_data_l, exp_l);
      check("hold_pass_cnt", BUS'(pass_cnt_r), BUS'(0));
    end
    in_valid = 1'b0;
    check("out_data_relu", out_data_r, exp_r);
    check("out_data_lin", out_data_l, exp_l);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_ctrl("release", 1'b1, 1'b0);
    $display("vec %0d: relu=%h lin=%h", vec_id, out_data_r[17:0], out_data_l[17:0]);
    vec_id++;
  endtask

  task automatic load_tbl(input vec_t v);
    pass_data[0] = bcast(v.i0);
    pass_data[1] = bcast(v.i1);
    pass_data[2] = bcast(v.i2);
    pass_data[3] = bcast(v.i3);
  endtask

  initial begin
    tbl[0] = '{18'sd100, 18'sd200, 18'sd300, 18'sd400, -18'sd260, 18'sd740, 18'sd740};
    tbl[1] = '{-18'sd10, -18'sd20, -18'sd30, -18'sd40, -18'sd260, 18'sd0, -18'sd360};
    tbl[2] = '{18'sd131071, 18'sd131071, 18'sd131071, 18'sd131071, 18'sd131071,
               18'sd131071, 18'sd131071};
    tbl[3] = '{-18'sd131072, -18'sd131072, -18'sd131072, -18'sd131072, -18'sd131072,
               18'sd0, -18'sd131072};
    tbl[4] = '{18'sd131071, 18'sd131071, -18'sd131072, -18'sd131072, 18'sd0,
               18'sd0, -18'sd2};
    tbl[5] = '{18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd131071, 18'sd131071, 18'sd131071};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    bias      = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_ctrl("reset", 1'b1, 1'b0);
    check("reset_pass_cnt", BUS'(pass_cnt_r), BUS'(0));
    check("reset_out_data", out_data_r, '0);
    rst_n = 1'b1;

    // Table vectors, no bubbles, no backpressure
    for (int k = 0; k < 6; k++) begin
      load_tbl(tbl[k]);
      run_vec(bcast(tbl[k].b), 0, 0, bcast(tbl[k].e_relu), bcast(tbl[k].e_lin));
    end

    // Backpressure: five held cycles with stray in_valid pulses
    load_tbl(tbl[0]);
    run_vec(bcast(tbl[0].b), 0, 5, bcast(18'sd740), bcast(18'sd740));

    // Bubbles between passes give the same result
    load_tbl(tbl[0]);
    run_vec(bcast(tbl[0].b), 3, 0, bcast(18'sd740), bcast(18'sd740));

    // Reset after two accepted passes discards the partial vector
    for (int p = 0; p < 2; p++) begin
      in_valid = 1'b1;
      in_data  = rand_bus();
      bias     = rand_bus();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("mid_pass_cnt", BUS'(pass_cnt_r), BUS'(2));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_pass_cnt", BUS'(pass_cnt_r), BUS'(0));
    check_ctrl("rst_mid", 1'b1, 1'b0);
    check("rst_out_data", out_data_l, '0);
    for (int p = 0; p < NP; p++) pass_data[p] = bcast(18'sd1);
    run_vec('0, 0, 0, bcast(18'sd4), bcast(18'sd4));

    // Randomized vectors against the reference model
    for (int v = 0; v < 30; v++) begin
      logic [BUS-1:0] b;
      for (int p = 0; p <= NP; p++) begin
        logic [BUS-1:0] r;
        for (int i = 0; i < N; i++) begin
          case ($urandom_range(0, 2))
            0: r[i*18 +: 18] = 18'($urandom);
            1: r[i*18 +: 18] = 18'(int'($urandom_range(0, 2000)) - 1000);
            default: r[i*18 +: 18] = $urandom_range(0, 1) ? 18'h1FFFF : 18'h20000;
          endcase
        end
        if (p == NP) b = r;
        else pass_data[p] = r;
      end
      run_vec(b, 2, $urandom_range(0, 3), model(b, 1'b1), model(b, 1'b0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
